channel_ctrl: RTL and testbench
===============================

# channel_ctrl

Per-channel digital controller that drives one analog front-end channel (CSA, discriminator, async SAR ADC) and collects its results. It synchronises the discriminator `hit` and ADC `done` flags, sequences `sample` and `csa_reset`, and captures the ADC word together with a timestamp. It presents the result as a one-entry valid/ready event toward the chip event router. One instance sits beside each analog channel.

## Interface
Parameters:
- `ADCBITS`, 10, ADC word width.
- `TS_BITS`, 24, timestamp counter width.
- `SAMPLE_CYCLES`, 4, cycles `sample` stays high after a hit is accepted (range 1..255).
- `RESET_CYCLES`, 8, cycles `csa_reset` stays high after each event (range 1..255).
- `CONV_TIMEOUT`, 64, maximum cycles to wait for `done` (range 1..1023).

Ports:
- `clk` input 1: clock.
- `reset_n` input 1: asynchronous reset, active-low.
- `hit` input 1: discriminator output; asynchronous to `clk`.
- `done` input 1: ADC conversion complete; asynchronous to `clk`.
- `dout` input ADCBITS: ADC result; valid while `done` is high.
- `enable` input 1: channel armed; when low, `hit` is ignored in IDLE.
- `sample` output 1: high to sample the CSA output; the falling edge starts the ADC conversion.
- `csa_reset` output 1: high resets the CSA and re-arms the discriminator.
- `event_valid` output 1: an event word is held.
- `event_ready` input 1: consumer accepts the word.
- `event_data` output TS_BITS+ADCBITS: {timestamp, adc}.
- `overflow` output 1: sticky; set when an event is dropped.
- `timeout_err` output 1: sticky; set when the conversion timeout expires.
- `clear_flags` input 1: synchronous clear of both sticky flags.

## Operation
- `hit` and `done` each pass through a 2-flop synchroniser. Below, `hit_s` and `done_s` are the synchroniser outputs.
- `ts` is a free-running TS_BITS counter. It increments every cycle and wraps from all-ones to 0. It is 0 after reset.
- FSM states: RESET, IDLE, SAMPLE, CONVERT.
  - **RESET**
    - `csa_reset`=1.
    - Counter loaded with RESET_CYCLES; the state lasts exactly RESET_CYCLES cycles, then goes to IDLE.
  - **IDLE**
    - Both outputs low.
    - If `hit_s`=1 and `enable`=1: latch `ts_cap`<=`ts`, then go to SAMPLE.
  - **SAMPLE**
    - `sample`=1 for exactly SAMPLE_CYCLES cycles, then go to CONVERT.
  - **CONVERT**
    - `sample`=0. Wait for `done_s`=1.
    - On `done_s`=1, capture `dout` into `adc_cap`, attempt the event push, then go to RESET.
    - If CONV_TIMEOUT cycles elapse without `done_s`: set `timeout_err`, push no event, go to RESET.
- Event push:
  - If the output register is empty, or is being accepted this same cycle (`event_valid`&&`event_ready`), load {`ts_cap`,`adc_cap`} and set `event_valid`=1.
  - Otherwise drop the new event, set `overflow`, and keep the held word unchanged.
- `event_valid` falls on the cycle after a handshake (`event_valid`&&`event_ready`), unless a push occurs in that same cycle. `event_data` is stable while `event_valid`=1 and not accepted.
- `enable` falling in SAMPLE or CONVERT does not abort the sequence. It takes effect in the next IDLE.
- `hit_s` still high when entering IDLE is treated as a new hit; the discriminator is expected to be cleared by `csa_reset`.
- `clear_flags` and a flag-set event in the same cycle: set wins.

## Timing
- Reset values:
  - state=RESET with the counter loaded to RESET_CYCLES.
  - `csa_reset`=1, `sample`=0.
  - `event_valid`=0, `event_data`=0.
  - `overflow`=0, `timeout_err`=0, `ts`=0.
- After `reset_n` deasserts, `csa_reset` stays high for RESET_CYCLES cycles. This happens whether reset is asserted while idle or in the middle of a sequence.
- `hit` rising to `sample` rising: 3 cycles (2 synchroniser cycles plus 1 FSM cycle). `ts_cap` equals `ts` at the edge where IDLE sees `hit_s`.
- `done` rising to `event_valid` rising: 3 cycles. `csa_reset` rises in the same cycle as `event_valid`.
- Minimum hit-to-hit period: 3 + SAMPLE_CYCLES + (conversion + 2) + RESET_CYCLES + 1 cycles.
- All outputs are registered. No combinational path from any input to any output.

## Test plan
- **Reset:** assert `reset_n`=0 mid-CONVERT, then release. Required: `csa_reset`=1 for exactly 8 cycles, then IDLE; `event_valid`=0; both flags 0.
- **Single hit:** `hit` pulse at `ts`=100 (model visible `ts`), `done` 20 cycles after `sample` falls, `dout`=0x2A5, `event_ready`=1. Required: one event {`ts_cap`, 0x2A5} where `ts_cap` = `ts` at hit acceptance; `sample` high exactly 4 cycles; `csa_reset` high 8 cycles afterwards.
- **Backpressure:** `event_ready`=0, two hits in sequence. Required: first word held unchanged; second dropped; `overflow`=1. Then `event_ready`=1 for 1 cycle: `event_valid` goes to 0.
- **Same-cycle accept and push:** `event_ready` rises in the same cycle the second event is pushed. Required: second word loaded; `overflow` stays 0.
- **Timeout:** hit with `done` never asserted. Required: `timeout_err`=1 exactly 64 cycles after entering CONVERT; no event; RESET follows. `clear_flags`=1 then clears the flag.
- **Disabled and wrap:** `enable`=0 with `hit` high. Required: no `sample` activity. With TS_BITS=4 and a hit while `ts` passes 15: the counter wraps to 0 and `ts_cap` is correct.

Source files
------------

// File: rtl/channel_ctrl.sv
// channel_ctrl: per-channel sequencer for one analog front-end channel
// (CSA, discriminator, async SAR ADC). It synchronises hit/done, drives
// sample and csa_reset, and presents {timestamp, adc} as a one-entry
// valid/ready event.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RESET   | csa_reset high for RESET_CYCLES, discriminator re-arming
// IDLE    | waiting for a synchronised hit while enabled
// SAMPLE  | sample high for SAMPLE_CYCLES; falling edge starts the ADC
// CONVERT | waiting for done (bounded by CONV_TIMEOUT), then push event
module channel_ctrl #(
  parameter int ADCBITS       = 10,
  parameter int TS_BITS       = 24,
  parameter int SAMPLE_CYCLES = 4,
  parameter int RESET_CYCLES  = 8,
  parameter int CONV_TIMEOUT  = 64
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       hit_i,
  input  logic                       done_i,
  input  logic [ADCBITS-1:0]         dout_i,
  input  logic                       enable_i,
  output logic                       sample_o,
  output logic                       csa_reset_o,
  output logic                       event_valid_o,
  input  logic                       event_ready_i,
  output logic [TS_BITS+ADCBITS-1:0] event_data_o,
  output logic                       overflow_o,
  output logic                       timeout_err_o,
  input  logic                       clear_flags_i
);

  // One down-counter serves all three timed states; 10 bits covers CONV_TIMEOUT.
  localparam int CW = 10;
  localparam logic [CW-1:0] RESET_LOAD  = CW'(RESET_CYCLES);
  localparam logic [CW-1:0] SAMPLE_LOAD = CW'(SAMPLE_CYCLES);
  localparam logic [CW-1:0] CONV_LOAD   = CW'(CONV_TIMEOUT);
  localparam logic [CW-1:0] CNT_TC      = CW'(1);

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_IDLE    = 2'd1,
    ST_SAMPLE  = 2'd2,
    ST_CONVERT = 2'd3
  } state_t;

  state_t                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         hit_meta_q, hit_s_q;
  logic                         done_meta_q, done_s_q;
  logic [TS_BITS-1:0]           ts_q;
  logic [TS_BITS-1:0]           ts_cap_q, ts_cap_d;
  logic                         sample_q, sample_d;
  logic                         csa_reset_q, csa_reset_d;
  logic                         ev_valid_q, ev_valid_d;
  logic [TS_BITS+ADCBITS-1:0]   ev_data_q, ev_data_d;
  logic                         overflow_q, overflow_d;
  logic                         timeout_q, timeout_d;
  logic                         handshake;

  // Two-flop synchronisers for the asynchronous discriminator and ADC flags.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      hit_meta_q  <= 1'b0;
      hit_s_q     <= 1'b0;
      done_meta_q <= 1'b0;
      done_s_q    <= 1'b0;
    end else begin
      hit_meta_q  <= hit_i;
      hit_s_q     <= hit_meta_q;
      done_meta_q <= done_i;
      done_s_q    <= done_meta_q;
    end
  end

  // Free-running timestamp, wraps naturally at all-ones.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) ts_q <= '0;
    else            ts_q <= ts_q + TS_BITS'(1);
  end

  assign handshake = ev_valid_q && event_ready_i;

  // Next-state, counter, output and event-register logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ts_cap_d    = ts_cap_q;
    sample_d    = sample_q;
    csa_reset_d = csa_reset_q;
    ev_valid_d  = ev_valid_q;
    ev_data_d   = ev_data_q;
    overflow_d  = overflow_q;
    timeout_d   = timeout_q;

    if (handshake) ev_valid_d = 1'b0;
    // Clear first so that a flag set later in this block takes priority.
    if (clear_flags_i) begin
      overflow_d = 1'b0;
      timeout_d  = 1'b0;
    end

    case (state_q)
      ST_RESET: begin
        if (cnt_q == CNT_TC) begin
          state_d     = ST_IDLE;
          csa_reset_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_TC;
        end
      end
      ST_IDLE: begin
        if (hit_s_q && enable_i) begin
          ts_cap_d = ts_q;
          state_d  = ST_SAMPLE;
          cnt_d    = SAMPLE_LOAD;
          sample_d = 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (cnt_q == CNT_TC) begin
          state_d  = ST_CONVERT;
          cnt_d    = CONV_LOAD;
          sample_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_TC;
        end
      end
      ST_CONVERT: begin
        if (done_s_q) begin
          // dout has been stable since done rose two cycles earlier.
          if (!ev_valid_q || handshake) begin
            ev_valid_d = 1'b1;
            ev_data_d  = {ts_cap_q, dout_i};
          end else begin
            overflow_d = 1'b1;
          end
          state_d     = ST_RESET;
          cnt_d       = RESET_LOAD;
          csa_reset_d = 1'b1;
        end else if (cnt_q == CNT_TC) begin
          timeout_d   = 1'b1;
          state_d     = ST_RESET;
          cnt_d       = RESET_LOAD;
          csa_reset_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_TC;
        end
      end
      default: begin
        state_d     = ST_RESET;
        cnt_d       = RESET_LOAD;
        sample_d    = 1'b0;
        csa_reset_d = 1'b1;
      end
    endcase
  end

  // Registered FSM state, counter and all outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_RESET;
      cnt_q       <= RESET_LOAD;
      ts_cap_q    <= '0;
      sample_q    <= 1'b0;
      csa_reset_q <= 1'b1;
      ev_valid_q  <= 1'b0;
      ev_data_q   <= '0;
      overflow_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ts_cap_q    <= ts_cap_d;
      sample_q    <= sample_d;
      csa_reset_q <= csa_reset_d;
      ev_valid_q  <= ev_valid_d;
      ev_data_q   <= ev_data_d;
      overflow_q  <= overflow_d;
      timeout_q   <= timeout_d;
    end
  end

  assign sample_o      = sample_q;
  assign csa_reset_o   = csa_reset_q;
  assign event_valid_o = ev_valid_q;
  assign event_data_o  = ev_data_q;
  assign overflow_o    = overflow_q;
  assign timeout_err_o = timeout_q;

endmodule

// File: tb/tb_channel_ctrl.sv
// Bench for channel_ctrl: default instance plus a TS_BITS=4 instance sharing
// stimulus for the timestamp wrap case.
module tb_channel_ctrl;

  localparam int ADCB = 10;
  localparam int TSB  = 24;
  localparam int TSS  = 4;
  localparam int EW   = TSB + ADCB;
  localparam int SEW  = TSS + ADCB;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            hit = 1'b0;
  logic            done = 1'b0;
  logic [ADCB-1:0] dout = '0;
  logic            enable = 1'b0;
  logic            event_ready = 1'b0;
  logic            clear_flags = 1'b0;

  logic            sample, csa_reset, ev_valid, overflow, tmo;
  logic [EW-1:0]   ev_data;
  logic            s_sample, s_csa, s_valid, s_ovf, s_tmo;
  logic [SEW-1:0]  s_data;

  channel_ctrl dut (
    .clk_i(clk), .reset_n_i(reset_n), .hit_i(hit), .done_i(done), .dout_i(dout),
    .enable_i(enable), .sample_o(sample), .csa_reset_o(csa_reset),
    .event_valid_o(ev_valid), .event_ready_i(event_ready), .event_data_o(ev_data),
    .overflow_o(overflow), .timeout_err_o(tmo), .clear_flags_i(clear_flags)
  );

  channel_ctrl #(.TS_BITS(TSS)) dut_small (
    .clk_i(clk), .reset_n_i(reset_n), .hit_i(hit), .done_i(done), .dout_i(dout),
    .enable_i(enable), .sample_o(s_sample), .csa_reset_o(s_csa),
    .event_valid_o(s_valid), .event_ready_i(event_ready), .event_data_o(s_data),
    .overflow_o(s_ovf), .timeout_err_o(s_tmo), .clear_flags_i(clear_flags)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [EW-1:0]  exp_q[$];
  logic [TSB-1:0] ts_m;

  // Reference timestamp: zero in reset, +1 per clock afterwards.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) ts_m <= '0;
    else          ts_m <= ts_m + 1'b1;
  end

  typedef struct {
    logic [ADCB-1:0] d;
    int              gap;
    logic            ready;
    logic            push;
    logic            ovf;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one cycle; a handshake seen at the negedge pops the scoreboard.
  task automatic tick();
    @(negedge clk);
    if (reset_n && ev_valid && event_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_event: got %0h expected none", ev_data);
      end else begin
        chk("event_data", 64'(ev_data), 64'(exp_q.pop_front()));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic measure_csa(input string name);
    int n = 0;
    while (csa_reset && n < 40) begin
      n++;
      tick();
    end
    chk(name, 64'(n), 64'(8));
  endtask

  // Hit pulse from IDLE; returns on the edge where sample falls (CONVERT entry).
  task automatic start_hit(output logic [TSB-1:0] exp_ts);
    int n = 0;
    hit = 1'b1;
    exp_ts = ts_m + 24'd2;
    tick();
    hit = 1'b0;
    tick();
    chk("sample_pre", 64'(sample), 64'(0));
    tick();
    chk("sample_latency", 64'(sample), 64'(1));
    while (sample && n < 40) begin
      n++;
      tick();
    end
    chk("sample_len", 64'(n), 64'(4));
  endtask

  task automatic finish_done(input logic [ADCB-1:0] d, input int gap,
                             input logic [TSB-1:0] exp_ts, input logic exp_push,
                             input logic late_ready);
    repeat (gap) tick();
    done = 1'b1;
    dout = d;
    if (exp_push) exp_q.push_back({exp_ts, d});
    tick();
    tick();
    chk("done_pre", 64'(csa_reset), 64'(0));
    if (late_ready) event_ready = 1'b1;
    tick();
    chk("done_latency", 64'(csa_reset), 64'(1));
    chk("valid_after_done", 64'(ev_valid), 64'(1));
    if (exp_push) chk("pushed_word", 64'(ev_data), 64'({exp_ts, d}));
    done = 1'b0;
    measure_csa("reset_len");
  endtask

  initial begin
    vec_t            vecs[5];
    logic [TSB-1:0]  t;
    logic [TSB-1:0]  t2;
    logic [SEW-1:0]  sw;
    int              n;

    vecs[0] = '{10'h000,  0, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{10'h3FF,  5, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{10'h155, 60, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{10'h111,  3, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{10'h222,  3, 1'b0, 1'b0, 1'b1};

    enable = 1'b1;
    event_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_csa", 64'(csa_reset), 64'(1));
    chk("rst_sample", 64'(sample), 64'(0));
    chk("rst_valid", 64'(ev_valid), 64'(0));
    chk("rst_data", 64'(ev_data), 64'(0));
    chk("rst_flags", 64'({overflow, tmo}), 64'(0));
    reset_n = 1'b1;
    measure_csa("por_reset_len");

    // Single hit at ts=100.
    n = 0;
    while (ts_m != 24'd100 && n < 300) begin
      n++;
      tick();
    end
    chk("reach_ts100", 64'(ts_m), 64'(100));
    start_hit(t);
    finish_done(10'h2A5, 20, t, 1'b1, 1'b0);

    // Table: normal events, then backpressure (held, dropped).
    for (int i = 0; i < 5; i++) begin
      event_ready = vecs[i].ready;
      start_hit(t);
      finish_done(vecs[i].d, vecs[i].gap, t, vecs[i].push, 1'b0);
      chk("overflow_vec", 64'(overflow), 64'(vecs[i].ovf));
    end
    chk("held_count", 64'(exp_q.size()), 64'(1));
    if (exp_q.size() > 0) chk("held_word", 64'(ev_data), 64'(exp_q[0]));
    event_ready = 1'b1;
    tick();
    event_ready = 1'b0;
    chk("valid_after_accept", 64'(ev_valid), 64'(0));
    chk("overflow_sticky", 64'(overflow), 64'(1));

    // Reset in the middle of CONVERT.
    start_hit(t);
    repeat (5) tick();
    reset_n = 1'b0;
    tick();
    chk("midrst_csa", 64'(csa_reset), 64'(1));
    chk("midrst_valid", 64'(ev_valid), 64'(0));
    chk("midrst_flags", 64'({overflow, tmo}), 64'(0));
    reset_n = 1'b1;
    measure_csa("midrst_reset_len");
    chk("midrst_idle_sample", 64'(sample), 64'(0));

    // Accept and push in the same cycle.
    start_hit(t);
    finish_done(10'h0AA, 4, t, 1'b1, 1'b0);
    start_hit(t2);
    finish_done(10'h0BB, 4, t2, 1'b1, 1'b1);
    chk("same_cycle_ovf", 64'(overflow), 64'(0));

    // Conversion timeout.
    start_hit(t);
    repeat (63) tick();
    chk("tmo_early", 64'(tmo), 64'(0));
    tick();
    chk("tmo_set", 64'(tmo), 64'(1));
    chk("tmo_csa", 64'(csa_reset), 64'(1));
    chk("tmo_no_event", 64'(ev_valid), 64'(0));
    measure_csa("tmo_reset_len");
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    chk("tmo_cleared", 64'(tmo), 64'(0));

    // Disabled channel ignores hit.
    enable = 1'b0;
    hit = 1'b1;
    n = 0;
    repeat (12) begin
      tick();
      if (sample) n++;
    end
    chk("disabled_no_sample", 64'(n), 64'(0));
    hit = 1'b0;
    repeat (4) tick();
    enable = 1'b1;

    // Timestamp wrap on the 4-bit instance.
    n = 0;
    while (ts_m[3:0] != 4'd14 && n < 40) begin
      n++;
      tick();
    end
    start_hit(t);
    repeat (10) tick();
    done = 1'b1;
    dout = 10'h1C3;
    exp_q.push_back({t, 10'h1C3});
    sw = {t[TSS-1:0], 10'h1C3};
    repeat (3) tick();
    chk("wrap_word", 64'(s_data), 64'(sw));
    chk("wrap_valid", 64'(s_valid), 64'(1));
    chk("wrap_csa", 64'(s_csa), 64'(1));
    chk("wrap_sample", 64'(s_sample), 64'(0));
    chk("wrap_flags", 64'({s_ovf, s_tmo}), 64'(0));
    done = 1'b0;
    measure_csa("wrap_reset_len");

    repeat (3) tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
